// File: rtl/ofifo_deskew.sv
// Output FIFO with per-lane deskew.
// Each array column writes into its own circular lane whenever its data
// arrives; a single read pops the head of every lane at once, so rows
// leave the block aligned even though columns arrive skewed in time.
module ofifo_deskew #(
    parameter int col   = 8,
    parameter int bw    = 16,
    parameter int depth = 64   // power of 2, at least 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col-1:0][bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col-1:0][bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_ready,
    output logic                     o_full,
    output logic                     o_overflow
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    // Per-lane storage and control state.
    logic [bw-1:0] mem   [col][depth];
    logic [aw-1:0] wptr  [col];
    logic [aw-1:0] rptr  [col];
    logic [cw-1:0] count [col];

    logic [col-1:0] lane_nonempty;
    logic [col-1:0] lane_full;
    logic [col-1:0] wr_ok;
    logic           rd_ok;

    // Per-lane status and write acceptance, from counts before the edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        lane_nonempty = '0;
        lane_full     = '0;
        wr_ok         = '0;
        for (int i = 0; i < col; i++) begin
            lane_nonempty[i] = (count[i] != '0);
            lane_full[i]     = (count[i] == full_cnt);
            wr_ok[i]         = wr[i] && !lane_full[i];
        end
    end

    assign o_valid = &lane_nonempty;
    assign o_ready = ~|lane_full;
    assign o_full  = &lane_full;
    assign rd_ok   = rd && o_valid;

    // Lane storage: write accepted data at each lane's write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; cleared pointers and counts make stale entries unreachable.
        for (int i = 0; i < col; i++) begin
            if (!reset && wr_ok[i]) begin
                mem[i][wptr[i]] <= in[i];
            end
        end
    end

    // Pointers, counts, aligned output row and sticky overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
            out        <= '0;
            o_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_ok[i]) begin
                    wptr[i] <= wptr[i] + aw'(1);
                end
                if (rd_ok) begin
                    rptr[i] <= rptr[i] + aw'(1);
                    out[i]  <= mem[i][rptr[i]];
                end
                // Simultaneous write and read leaves occupancy unchanged.
                case ({wr_ok[i], rd_ok})
                    2'b10:   count[i] <= count[i] + cw'(1);
                    2'b01:   count[i] <= count[i] - cw'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (|(wr & lane_full)) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofifo_deskew.sv
// Bench for ofifo_deskew: directed stimulus with a per-lane reference
// queue model; expected rows go into a scoreboard that a separate monitor
// drains whenever the DUT accepts a read.
module tb_ofifo_deskew;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    typedef logic [COL-1:0][BW-1:0] row_t;

    logic           clk;
    logic           reset;
    row_t           in_d;
    logic [COL-1:0] wr;
    logic           rd;
    row_t           out_d;
    logic           o_valid;
    logic           o_ready;
    logic           o_full;
    logic           o_overflow;

    ofifo_deskew #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_d),
        .wr        (wr),
        .rd        (rd),
        .out       (out_d),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_full    (o_full),
        .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_rows = 0;

    // Reference model state.
    logic [BW-1:0] lane_q [COL][$];
    row_t          exp_q[$];
    row_t          last_row_m = '0;
    logic          ovf_m = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_valid();
        logic v = 1'b1;
        for (int i = 0; i < COL; i++) if (lane_q[i].size() == 0) v = 1'b0;
        return v;
    endfunction

    task automatic check_flags(input string tag);
        logic v = 1'b1;
        logic r = 1'b1;
        logic f = 1'b1;
        for (int i = 0; i < COL; i++) begin
            if (lane_q[i].size() == 0)     v = 1'b0;
            if (lane_q[i].size() == DEPTH) r = 1'b0;
            if (lane_q[i].size() != DEPTH) f = 1'b0;
        end
        check({tag, "_valid"}, 128'(o_valid), 128'(v));
        check({tag, "_ready"}, 128'(o_ready), 128'(r));
        check({tag, "_full"},  128'(o_full),  128'(f));
        check({tag, "_ovf"},   128'(o_overflow), 128'(ovf_m));
    endtask

    // One clock: drive inputs, update the model, advance past the edge.
    task automatic cycle(input logic [COL-1:0] w, input row_t d, input logic r);
        logic [COL-1:0] acc;
        logic           fire;
        row_t           row;
        wr   = w;
        in_d = d;
        rd   = r;
        fire = r && model_valid();
        acc  = '0;
        row  = '0;
        for (int i = 0; i < COL; i++) begin
            if (w[i]) begin
                if (lane_q[i].size() < DEPTH) acc[i] = 1'b1;
                else                          ovf_m  = 1'b1;
            end
        end
        if (fire) begin
            for (int i = 0; i < COL; i++) row[i] = lane_q[i].pop_front();
            exp_q.push_back(row);
            last_row_m = row;
        end
        for (int i = 0; i < COL; i++) if (acc[i]) lane_q[i].push_back(d[i]);
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic do_reset(input logic [COL-1:0] w, input logic r);
        reset = 1'b1;
        wr    = w;
        rd    = r;
        in_d  = {COL{16'hFFFF}};
        for (int i = 0; i < COL; i++) lane_q[i].delete();
        ovf_m      = 1'b0;
        last_row_m = '0;
        @(posedge clk);
        #1;
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_out", out_d, 128'(0));
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
    endtask

    // Monitor: a read accepted at an edge shows on out at the next negedge.
    logic pending = 1'b0;
    row_t mon_exp;
    always @(negedge clk) begin
        if (pending) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 128'(1), 128'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check($sformatf("row%0d", n_rows), out_d, mon_exp);
            end
            n_rows++;
        end
        pending = rd && o_valid && !reset;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t           d;
        logic [COL-1:0] w;
        int             k;

        reset = 1'b1;
        wr    = '0;
        rd    = 1'b0;
        in_d  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset");
        check("reset_out", out_d, 128'(0));
        reset = 1'b0;

        // Skewed fill: lane i gets 0x0100*i+k at cycle k+i.
        for (int t = 0; t <= 10; t++) begin
            w = '0;
            d = '0;
            for (int i = 0; i < COL; i++) begin
                k = t - i;
                if (k >= 0 && k <= 3) begin
                    w[i] = 1'b1;
                    d[i] = 16'(16'h0100 * i + k);
                end
            end
            cycle(w, d, 1'b0);
            check($sformatf("skew_valid%0d", t), 128'(o_valid), 128'(t >= 7));
            check_flags($sformatf("skew%0d", t));
        end
        for (int j = 0; j < 4; j++) begin
            cycle('0, '0, 1'b1);
            for (int i = 0; i < COL; i++) d[i] = 16'(16'h0100 * i + j);
            check($sformatf("skew_row%0d", j), out_d, d);
        end
        check_flags("skew_drained");

        // Full and overflow, including a write to a full lane alongside a read.
        for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < COL; i++) d[i] = 16'(16'h1000 * i + j);
            cycle('1, d, 1'b0);
        end
        check_flags("full");
        check("full_o_full", 128'(o_full), 128'(1));
        check("full_o_ready", 128'(o_ready), 128'(0));
        cycle(8'h08, {COL{16'hDEAD}}, 1'b0);
        check("ovf_flag", 128'(o_overflow), 128'(1));
        check_flags("ovf");
        cycle(8'h08, {COL{16'hBEEF}}, 1'b1);
        check_flags("full_rw");
        for (int j = 1; j < DEPTH; j++) cycle('0, '0, 1'b1);
        check_flags("full_drained");
        check("full_drained_valid", 128'(o_valid), 128'(0));
        check("ovf_sticky", 128'(o_overflow), 128'(1));

        // Partial valid: lane 7 empty, rd held high.
        for (int i = 0; i < COL; i++) d[i] = 16'(16'h0A00 + i);
        cycle(8'h7F, d, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cycle('0, '0, 1'b1);
            check($sformatf("pv_out%0d", j), out_d, last_row_m);
            check_flags($sformatf("pv%0d", j));
        end
        cycle(8'h80, {COL{16'h0A77}}, 1'b1);
        check("pv_out_hold", out_d, last_row_m);
        check_flags("pv_lane7");
        cycle('0, '0, 1'b1);
        d = '0;
        for (int i = 0; i < COL - 1; i++) d[i] = 16'(16'h0A00 + i);
        d[COL-1] = 16'h0A77;
        check("pv_row", out_d, d);
        check_flags("pv_done");

        // Simultaneous read and write at occupancy 5.
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < COL; i++) d[i] = 16'(16'h2000 + 16'h0100 * i + j);
            cycle('1, d, 1'b0);
        end
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < COL; i++) d[i] = 16'(16'h3000 + 16'h0100 * i + j);
            cycle('1, d, 1'b1);
            check_flags($sformatf("rw%0d", j));
        end
        for (int j = 0; j < 5; j++) cycle('0, '0, 1'b1);
        check("rw_empty_valid", 128'(o_valid), 128'(0));

        // Streaming with random write subsets; pointers wrap several times.
        for (int c = 0; c < 200; c++) begin
            w = COL'($urandom | $urandom);
            for (int i = 0; i < COL; i++) d[i] = 16'($urandom);
            cycle(w, d, model_valid());
            check_flags($sformatf("st%0d", c));
        end
        for (int j = 0; j < DEPTH + 8 && model_valid(); j++) cycle('0, '0, 1'b1);
        check_flags("st_drained");

        // Mid-run reset discards stored entries.
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < COL; i++) d[i] = 16'(16'h4000 + 16'h0100 * i + j);
            cycle('1, d, 1'b0);
        end
        do_reset('1, 1'b1);
        check_flags("post_rst");
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < COL; i++) d[i] = 16'(16'h5000 + 16'h0100 * i + j);
            cycle('1, d, 1'b0);
            check($sformatf("rst_out_zero%0d", j), out_d, 128'(0));
        end
        for (int j = 0; j < 3; j++) cycle('0, '0, 1'b1);
        check_flags("rst_done");
        for (int i = 0; i < COL; i++) d[i] = 16'(16'h5000 + 16'h0100 * i + 1);
        check("rst_last_row", out_d, d);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
